// File: rtl/bullet_pkg.sv
// Shared types and constants for the bullet pool: default field widths,
// color codes and the per-slot bullet record.
package bullet_pkg;

   localparam int DEFAULT_COORD_W = 8;
   localparam int DEFAULT_SPEED_W = 4;

   localparam logic [2:0] WHITE = 3'd0;
   localparam logic [2:0] GREEN = 3'd1;
   localparam logic [2:0] BLUE  = 3'd2;

   typedef struct packed {
      logic                       active;
      logic [2:0]                 color;
      logic [DEFAULT_SPEED_W-1:0] speed;
      logic [DEFAULT_COORD_W-1:0] w;
      logic [DEFAULT_COORD_W-1:0] h;
      logic [DEFAULT_COORD_W-1:0] x;
      logic [DEFAULT_COORD_W-1:0] y;
   } bullet_slot_t;

endpackage

// File: rtl/bullet_alloc.sv
// Lowest-index-free priority encoder: picks the slot a new bullet is written to.
module bullet_alloc #(
   parameter  int NUM_SLOTS = 8,
   localparam int IDX_W     = $clog2(NUM_SLOTS)
) (
   input  logic [NUM_SLOTS-1:0] free_i,
   output logic [IDX_W-1:0]     idx_o,
   output logic                 any_free_o
);

   always_comb begin
      // NOTE: outputs get defaults before the loop so no path leaves them unassigned (no latch).
      idx_o      = '0;
      any_free_o = 1'b0;
      // Scanning downwards lets the lowest free index be the last one written.
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (free_i[i]) begin
            idx_o      = IDX_W'(i);
            any_free_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bullet_pool.sv
// Fixed pool of bullet slots: spawn into the lowest free slot, per-tick vertical
// movement with wrap or retire, collision clear, and two combinational read ports.
module bullet_pool
   import bullet_pkg::*;
#(
   parameter  int NUM_SLOTS = 8,
   parameter  int COORD_W   = DEFAULT_COORD_W,
   parameter  int SPEED_W   = DEFAULT_SPEED_W,
   parameter  int Y_LIMIT   = 200,
   parameter  int Y_RESTART = 1,
   parameter  int WRAP_MODE = 1,
   localparam int IDX_W     = $clog2(NUM_SLOTS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 isRun,
   input  logic                 moveTick,
   input  logic                 spawnValid,
   input  logic [COORD_W-1:0]   spawnX,
   input  logic [COORD_W-1:0]   spawnY,
   input  logic [COORD_W-1:0]   spawnW,
   input  logic [COORD_W-1:0]   spawnH,
   input  logic [2:0]           spawnColor,
   input  logic [SPEED_W-1:0]   spawnSpeed,
   output logic                 spawnReady,
   input  logic [IDX_W-1:0]     renderIndex,
   output logic [2*COORD_W-1:0] renderPos,
   output logic [2*COORD_W-1:0] renderSize,
   output logic [2:0]           renderColor,
   output logic                 isRender1,
   input  logic [IDX_W-1:0]     colIndex,
   output logic [2*COORD_W-1:0] colPos,
   output logic [2*COORD_W-1:0] colSize,
   output logic [2:0]           colColor,
   output logic                 isRender2,
   input  logic                 isCollide,
   output logic [IDX_W:0]       liveCount,
   output logic                 full,
   output logic                 empty
);

   typedef struct packed {
      logic               active;
      logic [2:0]         color;
      logic [SPEED_W-1:0] speed;
      logic [COORD_W-1:0] w;
      logic [COORD_W-1:0] h;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } slot_t;

   localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(Y_LIMIT);
   localparam logic [COORD_W-1:0] Y_RST = COORD_W'(Y_RESTART);

   slot_t                slots_q [NUM_SLOTS];
   slot_t                slots_d [NUM_SLOTS];
   logic [IDX_W-1:0]     col_index_q;
   logic [NUM_SLOTS-1:0] free_vec;
   logic [IDX_W-1:0]     alloc_idx;
   logic                 any_free;
   logic                 spawn_fire;
   logic                 move_en;
   slot_t                spawn_slot;
   slot_t                render_slot;
   slot_t                col_slot;

   function automatic logic [COORD_W-1:0] advance_y(input logic [COORD_W-1:0] y,
                                                    input logic [SPEED_W-1:0] speed);
      logic [COORD_W:0] sum;
      sum = {1'b0, y} + (COORD_W+1)'(speed);
      return sum[COORD_W] ? {COORD_W{1'b1}} : sum[COORD_W-1:0];
   endfunction

   always_comb begin
      free_vec = '0;
      for (int i = 0; i < NUM_SLOTS; i++) free_vec[i] = !slots_q[i].active;
   end

   bullet_alloc #(.NUM_SLOTS(NUM_SLOTS)) u_alloc (
      .free_i     (free_vec),
      .idx_o      (alloc_idx),
      .any_free_o (any_free)
   );

   assign spawnReady = any_free;
   assign spawn_fire = spawnValid && any_free;
   assign move_en    = isRun && moveTick;
   assign spawn_slot = '{active: 1'b1, color: spawnColor, speed: spawnSpeed,
                         w: spawnW, h: spawnH, x: spawnX, y: spawnY};

   // Priority within a slot: move, then collide clear, then spawn overwrites all.
   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         slots_d[i] = slots_q[i];
         if (move_en && slots_q[i].active) begin
            if (slots_q[i].y >= Y_LIM) begin
               if (WRAP_MODE != 0) slots_d[i].y      = Y_RST;
               else                slots_d[i].active = 1'b0;
            end else begin
               slots_d[i].y = advance_y(slots_q[i].y, slots_q[i].speed);
            end
         end
         if (isCollide && col_index_q == IDX_W'(i)) slots_d[i].active = 1'b0;
         if (spawn_fire && alloc_idx == IDX_W'(i)) slots_d[i] = spawn_slot;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the whole slot array is cleared, not only the active bits, so every read returns zeros after reset.
         slots_q     <= '{default: '0};
         col_index_q <= '0;
      end else begin
         // NOTE: non-blocking updates so all slots and the index register sample pre-edge values.
         slots_q     <= slots_d;
         col_index_q <= colIndex;
      end
   end

   // Index compare against each legal slot leaves out-of-range reads at zero.
   always_comb begin
      render_slot = '0;
      col_slot    = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (renderIndex == IDX_W'(i)) render_slot = slots_q[i];
         if (colIndex == IDX_W'(i))    col_slot    = slots_q[i];
      end
   end

   assign renderPos   = {render_slot.x, render_slot.y};
   assign renderSize  = {render_slot.w, render_slot.h};
   assign renderColor = render_slot.color;
   assign isRender1   = render_slot.active;
   assign colPos      = {col_slot.x, col_slot.y};
   assign colSize     = {col_slot.w, col_slot.h};
   assign colColor    = col_slot.color;
   assign isRender2   = col_slot.active;

   always_comb begin
      liveCount = '0;
      for (int i = 0; i < NUM_SLOTS; i++) liveCount = liveCount + (IDX_W+1)'(slots_q[i].active);
   end

   assign full  = (liveCount == (IDX_W+1)'(NUM_SLOTS));
   assign empty = (liveCount == '0);

endmodule

// File: tb/tb_bullet_pool.sv
// Bench for bullet_pool: three configurations driven in lockstep and compared
// every cycle against a behavioural pool model, plus directed scenario checks.
`timescale 1ns/1ps
module tb_bullet_pool;
   import bullet_pkg::*;

   localparam int NI = 3;  // 0: wrap, 8 slots; 1: retire, 8 slots; 2: wrap, 6 slots, limit 250

   logic       clk = 1'b0;
   logic       reset, isRun, moveTick, spawnValid, isCollide;
   logic [7:0] spawnX, spawnY, spawnW, spawnH;
   logic [2:0] spawnColor;
   logic [3:0] spawnSpeed;
   logic [2:0] renderIndex, colIndex;

   logic        spawn_ready [NI];
   logic [15:0] render_pos  [NI];
   logic [15:0] render_size [NI];
   logic [2:0]  render_color[NI];
   logic        is_render1  [NI];
   logic [15:0] col_pos     [NI];
   logic [15:0] col_size    [NI];
   logic [2:0]  col_color   [NI];
   logic        is_render2  [NI];
   logic [3:0]  live_count  [NI];
   logic        full        [NI];
   logic        empty       [NI];

   int checks = 0;
   int errors = 0;

   always #10 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      bullet_pool #(
         .NUM_SLOTS (g == 2 ? 6 : 8),
         .WRAP_MODE (g == 1 ? 0 : 1),
         .Y_LIMIT   (g == 2 ? 250 : 200),
         .Y_RESTART (g == 2 ? 7 : 1)
      ) u_dut (
         .clk         (clk),
         .reset       (reset),
         .isRun       (isRun),
         .moveTick    (moveTick),
         .spawnValid  (spawnValid),
         .spawnX      (spawnX),
         .spawnY      (spawnY),
         .spawnW      (spawnW),
         .spawnH      (spawnH),
         .spawnColor  (spawnColor),
         .spawnSpeed  (spawnSpeed),
         .spawnReady  (spawn_ready[g]),
         .renderIndex (renderIndex),
         .renderPos   (render_pos[g]),
         .renderSize  (render_size[g]),
         .renderColor (render_color[g]),
         .isRender1   (is_render1[g]),
         .colIndex    (colIndex),
         .colPos      (col_pos[g]),
         .colSize     (col_size[g]),
         .colColor    (col_color[g]),
         .isRender2   (is_render2[g]),
         .isCollide   (isCollide),
         .liveCount   (live_count[g]),
         .full        (full[g]),
         .empty       (empty[g])
      );
   end

   // ---------------- behavioural model ----------------
   bullet_slot_t m_slot [NI][8];
   int           m_colq [NI];

   function automatic int ns(int m);   return (m == 2) ? 6 : 8;     endfunction
   function automatic bit wrap(int m); return (m != 1);             endfunction
   function automatic int lim(int m);  return (m == 2) ? 250 : 200; endfunction
   function automatic int rst(int m);  return (m == 2) ? 7 : 1;     endfunction

   function automatic int m_live(int m);
      int n = 0;
      for (int i = 0; i < ns(m); i++) if (m_slot[m][i].active) n++;
      return n;
   endfunction

   function automatic logic [35:0] m_read(int m, int r);
      if (r >= ns(m)) return '0;
      return {m_slot[m][r].active, m_slot[m][r].color, m_slot[m][r].x, m_slot[m][r].y,
              m_slot[m][r].w, m_slot[m][r].h};
   endfunction

   task automatic model_edge();
      for (int m = 0; m < NI; m++) begin
         bullet_slot_t nxt [8];
         int live, free_idx, s;
         if (reset) begin
            for (int i = 0; i < 8; i++) m_slot[m][i] = '0;
            m_colq[m] = 0;
         end else begin
            live     = m_live(m);
            free_idx = -1;
            for (int i = ns(m) - 1; i >= 0; i--) if (!m_slot[m][i].active) free_idx = i;
            for (int i = 0; i < 8; i++) nxt[i] = m_slot[m][i];
            if (isRun && moveTick) begin
               for (int i = 0; i < ns(m); i++) begin
                  if (nxt[i].active) begin
                     if (int'(nxt[i].y) >= lim(m)) begin
                        if (wrap(m)) nxt[i].y = 8'(rst(m));
                        else         nxt[i].active = 1'b0;
                     end else begin
                        s = int'(nxt[i].y) + int'(nxt[i].speed);
                        nxt[i].y = (s > 255) ? 8'd255 : 8'(s);
                     end
                  end
               end
            end
            if (isCollide && m_colq[m] < ns(m)) nxt[m_colq[m]].active = 1'b0;
            if (spawnValid && live < ns(m))
               nxt[free_idx] = '{active: 1'b1, color: spawnColor, speed: spawnSpeed,
                                 w: spawnW, h: spawnH, x: spawnX, y: spawnY};
            for (int i = 0; i < 8; i++) m_slot[m][i] = nxt[i];
            m_colq[m] = int'(colIndex);
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int m = 0; m < NI; m++) begin
         check($sformatf("live[%0d]", m),  64'(live_count[m]),  64'(m_live(m)));
         check($sformatf("full[%0d]", m),  64'(full[m]),        64'(m_live(m) == ns(m)));
         check($sformatf("empty[%0d]", m), 64'(empty[m]),       64'(m_live(m) == 0));
         check($sformatf("ready[%0d]", m), 64'(spawn_ready[m]), 64'(m_live(m) < ns(m)));
      end
      for (int r = 0; r < 8; r++) begin
         renderIndex = 3'(r);
         #1;
         for (int m = 0; m < NI; m++)
            check($sformatf("render[%0d][%0d]", m, r),
                  64'({is_render1[m], render_color[m], render_pos[m], render_size[m]}),
                  64'(m_read(m, r)));
      end
      for (int m = 0; m < NI; m++)
         check($sformatf("col[%0d][%0d]", m, colIndex),
               64'({is_render2[m], col_color[m], col_pos[m], col_size[m]}),
               64'(m_read(m, int'(colIndex))));
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic set_spawn(input int x, input int y, input int w, input int h,
                            input int color, input int speed);
      spawnX = 8'(x); spawnY = 8'(y); spawnW = 8'(w); spawnH = 8'(h);
      spawnColor = 3'(color); spawnSpeed = 4'(speed);
   endtask

   task automatic rand_spawn();
      set_spawn($urandom_range(0, 255),
                ($urandom_range(0, 3) == 0) ? $urandom_range(190, 255) : $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 7), $urandom_range(0, 15));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] y_hold;
      reset = 1'b1; isRun = 1'b0; moveTick = 1'b0; spawnValid = 1'b0; isCollide = 1'b0;
      renderIndex = '0; colIndex = '0;
      set_spawn(0, 0, 0, 0, 0, 0);
      step();
      do_reset();

      // Reset state
      check("rst_ready", 64'(spawn_ready[0]), 1);
      check("rst_empty", 64'(empty[0]), 1);
      check("rst_full",  64'(full[0]), 0);
      check("rst_live",  64'(live_count[0]), 0);

      // First spawn lands in slot 0
      set_spawn(16, 19, 16, 16, GREEN, 5);
      spawnValid = 1'b1;
      step();
      spawnValid = 1'b0;
      renderIndex = 3'd0; #1;
      check("spawn_pos",   64'(render_pos[0]), 64'h1013);
      check("spawn_size",  64'(render_size[0]), 64'h1010);
      check("spawn_color", 64'(render_color[0]), 64'(GREEN));
      check("spawn_act",   64'(is_render1[0]), 1);
      check("spawn_live",  64'(live_count[0]), 1);

      // Wrap versus retire at Y_LIMIT
      do_reset();
      set_spawn(40, 198, 4, 8, WHITE, 5);
      spawnValid = 1'b1; isRun = 1'b1; moveTick = 1'b1;
      step();
      spawnValid = 1'b0;
      renderIndex = 3'd0; #1;
      check("wrap_y0",   64'(render_pos[0][7:0]), 198);
      check("retire_y0", 64'(render_pos[1][7:0]), 198);
      step();
      renderIndex = 3'd0; #1;
      check("wrap_y1",   64'(render_pos[0][7:0]), 203);
      check("retire_y1", 64'(render_pos[1][7:0]), 203);
      step();
      renderIndex = 3'd0; #1;
      check("wrap_y2",     64'(render_pos[0][7:0]), 1);
      check("wrap_act",    64'(is_render1[0]), 1);
      check("retire_act",  64'(is_render1[1]), 0);
      check("retire_live", 64'(live_count[1]), 0);
      isRun = 1'b0; moveTick = 1'b0;

      // Fill the pool, drop the overflow spawn, free slot 3 and refill it
      do_reset();
      for (int k = 0; k < 9; k++) begin
         rand_spawn();
         spawnValid = 1'b1;
         step();
         if (k == 7) begin
            check("fill_full",  64'(full[0]), 1);
            check("fill_ready", 64'(spawn_ready[0]), 0);
         end
      end
      check("drop_live", 64'(live_count[0]), 8);
      spawnValid = 1'b0; colIndex = 3'd3;
      step();
      isCollide = 1'b1;
      step();
      isCollide = 1'b0;
      check("col3_live", 64'(live_count[0]), 7);
      set_spawn(77, 55, 3, 4, BLUE, 2);
      spawnValid = 1'b1;
      step();
      spawnValid = 1'b0;
      renderIndex = 3'd3; #1;
      check("refill_pos",  64'(render_pos[0]), 64'h4d37);
      check("refill_full", 64'(full[0]), 1);

      // colIndex is registered: collide applies to the previous cycle's index
      colIndex = 3'd2;
      step();
      isCollide = 1'b1; colIndex = 3'd0;
      step();
      isCollide = 1'b0;
      renderIndex = 3'd2; #1;
      check("col_prev_slot2", 64'(is_render1[0]), 0);
      renderIndex = 3'd0; #1;
      check("col_prev_slot0", 64'(is_render1[0]), 1);

      // isRun low freezes movement; a spawn in a move cycle keeps its spawnY
      y_hold = m_slot[0][0].y;
      isRun = 1'b0;
      for (int k = 0; k < 4; k++) begin
         moveTick = (k % 2 == 0);
         step();
      end
      renderIndex = 3'd0; #1;
      check("hold_y", 64'(render_pos[0][7:0]), 64'(y_hold));
      set_spawn(90, 150, 5, 5, GREEN, 9);
      spawnValid = 1'b1; isRun = 1'b1; moveTick = 1'b1;
      step();
      spawnValid = 1'b0;
      renderIndex = 3'd2; #1;
      check("spawn_move_y", 64'(render_pos[0][7:0]), 150);
      step();
      renderIndex = 3'd2; #1;
      check("after_move_y", 64'(render_pos[0][7:0]), 159);
      isRun = 1'b0; moveTick = 1'b0;

      // Reset mid-flight with five live bullets, spawn held high during reset
      do_reset();
      isRun = 1'b1;
      for (int k = 0; k < 5; k++) begin
         rand_spawn();
         spawnValid = 1'b1;
         moveTick = 1'($urandom_range(0, 1));
         step();
      end
      check("mid_live", 64'(live_count[0]), 5);
      reset = 1'b1; isCollide = 1'b1;
      step();
      reset = 1'b0; spawnValid = 1'b0; isCollide = 1'b0; isRun = 1'b0;
      renderIndex = 3'd0; colIndex = 3'd0; #1;
      check("mrst_live",  64'(live_count[0]), 0);
      check("mrst_empty", 64'(empty[0]), 1);
      check("mrst_full",  64'(full[0]), 0);
      check("mrst_ready", 64'(spawn_ready[0]), 1);
      check("mrst_rpos",  64'(render_pos[0]), 0);
      check("mrst_r1",    64'(is_render1[0]), 0);
      check("mrst_r2",    64'(is_render2[0]), 0);

      // Randomized traffic against the model
      for (int k = 0; k < 400; k++) begin
         reset      = ($urandom_range(0, 99) == 0);
         isRun      = ($urandom_range(0, 9) < 7);
         moveTick   = 1'($urandom_range(0, 1));
         spawnValid = 1'($urandom_range(0, 1));
         isCollide  = ($urandom_range(0, 9) < 3);
         colIndex   = 3'($urandom_range(0, 7));
         rand_spawn();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
